// File: rtl/servo_cmd_arbiter_if.sv
// Servo command arbiter bus: keyboard levels and UART bytes in, servo
// direction commands and ownership status out.
// When ARB_ESTOP_EN is defined the bus also carries the emergency-stop flag.
interface servo_cmd_arbiter_if;
    logic [3:0] kb_cw;
    logic [3:0] kb_ccw;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [3:0] cw;
    logic [3:0] ccw;
    logic [1:0] owner;
    logic       bt_valid;
`ifdef ARB_ESTOP_EN
    logic       estop;
`endif

    // Side that feeds the arbiter (decoders) and watches its outputs
    modport master (
        output kb_cw, kb_ccw, rx_data, rx_done,
        input  cw, ccw, owner, bt_valid
`ifdef ARB_ESTOP_EN
        , estop
`endif
    );

    // The arbiter itself
    modport slave (
        input  kb_cw, kb_ccw, rx_data, rx_done,
        output cw, ccw, owner, bt_valid
`ifdef ARB_ESTOP_EN
        , estop
`endif
    );
endinterface

// File: rtl/servo_cmd_arbiter.sv
// Servo command arbiter: shares the four servo channels between the PS/2
// keyboard (level-held keys) and the HC-06 UART (timed byte commands).
// One source owns the outputs at a time; every change of owner passes through
// an outputs-off guard interval.
// Optional feature macro: ARB_ESTOP_EN adds an emergency stop latched by byte
// 8'hFF and cleared by byte 8'hFE (or reset).
module servo_cmd_arbiter #(
    parameter int HOLD_CYCLES  = 10_000_000,
    parameter int GUARD_CYCLES = 100_000,
    parameter int CNT_W        = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    servo_cmd_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_KEYBOARD  = 2'b01,
        ST_BLUETOOTH = 2'b10,
        ST_GUARD     = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

    logic [3:0]       kb_cw_q;
    logic [3:0]       kb_ccw_q;
    logic             kb_active;
    logic [3:0]       kb_cw_ok;
    logic [3:0]       kb_ccw_ok;

    logic [3:0]       bt_cmd;
    logic [CNT_W-1:0] hold_cnt;
    logic             bt_valid;
    logic [2:0]       bt_idx;
    logic [3:0]       bt_cw_dec;
    logic [3:0]       bt_ccw_dec;
    logic             byte_is_move;
    logic             estop_active;

    state_t           state;
    state_t           state_next;
    logic [3:0]       cw_q;
    logic [3:0]       ccw_q;
    logic [3:0]       cw_next;
    logic [3:0]       ccw_next;
    logic [CNT_W-1:0] guard_cnt;
    logic [CNT_W-1:0] guard_cnt_next;

`ifdef ARB_ESTOP_EN
    logic             estop_q;
    assign estop_active = estop_q;
    assign bus.estop    = estop_q;
`else
    assign estop_active = 1'b0;
`endif

    // A channel with both keys held is driven in neither direction
    assign kb_active = |(kb_cw_q | kb_ccw_q);
    assign kb_cw_ok  = kb_cw_q & ~kb_ccw_q;
    assign kb_ccw_ok = kb_ccw_q & ~kb_cw_q;

    assign byte_is_move = (bus.rx_data >= 8'd1) && (bus.rx_data <= 8'd8);
    assign bt_valid     = (bt_cmd != 4'd0);
    assign bt_idx       = 3'(bt_cmd - 4'd1);

    // Keyboard levels are sampled once so every decision sees stable inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_cw_q  <= 4'd0;
            kb_ccw_q <= 4'd0;
        end else begin
            kb_cw_q  <= bus.kb_cw;
            kb_ccw_q <= bus.kb_ccw;
        end
    end

    // UART byte decode and command lifetime; a fresh byte beats expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bt_cmd   <= 4'd0;
            hold_cnt <= '0;
`ifdef ARB_ESTOP_EN
            estop_q  <= 1'b0;
`endif
        end else if (bus.rx_done && byte_is_move && !estop_active) begin
            bt_cmd   <= bus.rx_data[3:0];
            hold_cnt <= HOLD_LOAD;
        end else if (bus.rx_done && (bus.rx_data == 8'd0)) begin
            bt_cmd   <= 4'd0;
            hold_cnt <= '0;
`ifdef ARB_ESTOP_EN
        end else if (bus.rx_done && (bus.rx_data == 8'hFF)) begin
            bt_cmd   <= 4'd0;
            hold_cnt <= '0;
            estop_q  <= 1'b1;
        end else if (bus.rx_done && (bus.rx_data == 8'hFE)) begin
            estop_q  <= 1'b0;
`endif
        end else if (bt_valid) begin
            if (hold_cnt == '0) begin
                bt_cmd <= 4'd0;
            end else begin
                hold_cnt <= hold_cnt - CNT_W'(1);
            end
        end
    end

    // Command byte 2k+1 drives channel k clockwise, 2k+2 counter-clockwise
    always_comb begin
        bt_cw_dec  = 4'd0;
        bt_ccw_dec = 4'd0;
        if (bt_valid) begin
            if (bt_idx[0]) begin
                bt_ccw_dec[bt_idx[2:1]] = 1'b1;
            end else begin
                bt_cw_dec[bt_idx[2:1]] = 1'b1;
            end
        end
    end

    // Ownership state, outputs and guard counter move together on the clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cw_q      <= 4'd0;
            ccw_q     <= 4'd0;
            guard_cnt <= '0;
        end else begin
            state     <= state_next;
            cw_q      <= cw_next;
            ccw_q     <= ccw_next;
            guard_cnt <= guard_cnt_next;
        end
    end

    // Ownership decisions; outputs are computed for the state being entered
    always_comb begin
        state_next     = state;
        cw_next        = 4'd0;
        ccw_next       = 4'd0;
        guard_cnt_next = guard_cnt;
        case (state)
            ST_IDLE: begin
                if (!estop_active) begin
                    if (kb_active) begin
                        state_next = ST_KEYBOARD;
                        cw_next    = kb_cw_ok;
                        ccw_next   = kb_ccw_ok;
                    end else if (bt_valid) begin
                        state_next = ST_BLUETOOTH;
                        cw_next    = bt_cw_dec;
                        ccw_next   = bt_ccw_dec;
                    end
                end
            end
            ST_KEYBOARD: begin
                if (estop_active || !kb_active) begin
                    state_next     = ST_GUARD;
                    guard_cnt_next = GUARD_LOAD;
                end else begin
                    cw_next  = kb_cw_ok;
                    ccw_next = kb_ccw_ok;
                end
            end
            ST_BLUETOOTH: begin
                if (estop_active || kb_active || !bt_valid) begin
                    state_next     = ST_GUARD;
                    guard_cnt_next = GUARD_LOAD;
                end else begin
                    cw_next  = bt_cw_dec;
                    ccw_next = bt_ccw_dec;
                end
            end
            ST_GUARD: begin
                if (guard_cnt == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    guard_cnt_next = guard_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.cw       = cw_q;
    assign bus.ccw      = ccw_q;
    assign bus.owner    = state;
    assign bus.bt_valid = bt_valid;

endmodule

// File: tb/tb_servo_cmd_arbiter.sv
// Self-checking bench for servo_cmd_arbiter (HOLD_CYCLES=20, GUARD_CYCLES=4).
// Each test queues per-cycle stimulus together with the expected outputs,
// then replays the queue one clock at a time and compares.
// Estop scenarios are included when ARB_ESTOP_EN is defined.
module tb_servo_cmd_arbiter;

    localparam logic [1:0] OW_IDLE = 2'b00;
    localparam logic [1:0] OW_KB   = 2'b01;
    localparam logic [1:0] OW_BT   = 2'b10;
    localparam logic [1:0] OW_GD   = 2'b11;

    typedef struct packed {
        logic [3:0] kb_cw;
        logic [3:0] kb_ccw;
        logic [7:0] rx_data;
        logic       rx_done;
    } stim_t;

    logic clk;
    logic rst_n;
    int   n_compared;
    int   n_mismatched;

    stim_t       stim_q[$];
    logic [11:0] exp_q[$];

    servo_cmd_arbiter_if bus();

    servo_cmd_arbiter #(
        .HOLD_CYCLES (20),
        .GUARD_CYCLES(4),
        .CNT_W       (24)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs packed as {estop, owner, bt_valid, cw, ccw}
    function automatic logic [11:0] observed_out();
        logic est;
`ifdef ARB_ESTOP_EN
        est = bus.estop;
`else
        est = 1'b0;
`endif
        return {est, bus.owner, bus.bt_valid, bus.cw, bus.ccw};
    endfunction

    function automatic logic [11:0] ex(input logic est, input logic [1:0] own,
                                      input logic bv, input logic [3:0] cw,
                                      input logic [3:0] ccw);
        return {est, own, bv, cw, ccw};
    endfunction

    function automatic logic [11:0] e(input logic [1:0] own, input logic bv,
                                     input logic [3:0] cw, input logic [3:0] ccw);
        return {1'b0, own, bv, cw, ccw};
    endfunction

    task automatic push_step(input logic [3:0] kcw, input logic [3:0] kccw,
                             input logic [7:0] data, input logic done,
                             input logic [11:0] expected);
        stim_t s;
        s.kb_cw   = kcw;
        s.kb_ccw  = kccw;
        s.rx_data = data;
        s.rx_done = done;
        stim_q.push_back(s);
        exp_q.push_back(expected);
    endtask

    task automatic applyStimulus(input stim_t s);
        bus.kb_cw   = s.kb_cw;
        bus.kb_ccw  = s.kb_ccw;
        bus.rx_data = s.rx_data;
        bus.rx_done = s.rx_done;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        rst_n = 1'b0;
        applyStimulus('{kb_cw: 4'hF, kb_ccw: 4'h0, rx_data: 8'd1, rx_done: 1'b1});
        repeat (2) @(negedge clk);
        got = observed_out();
        n_compared++;
        if (got !== 12'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_hold: got %b expected %b", got, 12'd0);
        end
        applyStimulus('{kb_cw: 4'h0, kb_ccw: 4'h0, rx_data: 8'd0, rx_done: 1'b0});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        got = observed_out();
        n_compared++;
        if (got !== e(OW_IDLE, 1'b0, 4'd0, 4'd0)) begin
            n_mismatched++;
            $display("[TB] FAIL reset_release: got %b expected %b", got, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        end
    endtask

    task automatic test_keyboard_basic();
        stim_t s;
        logic [11:0] want, got;
        int step = 0;
        push_step(4'b0001, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'b0001, 4'd0, 8'd0, 1'b0, e(OW_KB, 1'b0, 4'b0001, 4'd0));
        push_step(4'b0001, 4'd0, 8'd0, 1'b0, e(OW_KB, 1'b0, 4'b0001, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_KB, 1'b0, 4'b0001, 4'd0));
        for (int i = 0; i < 4; i++) push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_GD, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = observed_out();
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("[TB] FAIL keyboard_basic step %0d: got %b expected %b", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_bluetooth_expiry();
        stim_t s;
        logic [11:0] want, got;
        int step = 0;
        push_step(4'd0, 4'd0, 8'd6, 1'b1, e(OW_IDLE, 1'b1, 4'd0, 4'd0));
        for (int i = 0; i < 19; i++) push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_BT, 1'b1, 4'd0, 4'b0100));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_BT, 1'b0, 4'd0, 4'b0100));
        for (int i = 0; i < 4; i++) push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_GD, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = observed_out();
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("[TB] FAIL bluetooth_expiry step %0d: got %b expected %b", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_keyboard_preempt();
        stim_t s;
        logic [11:0] want, got;
        int step = 0;
        push_step(4'd0, 4'd0, 8'd3, 1'b1, e(OW_IDLE, 1'b1, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_BT, 1'b1, 4'b0010, 4'd0));
        push_step(4'd0, 4'b1000, 8'd0, 1'b0, e(OW_BT, 1'b1, 4'b0010, 4'd0));
        for (int i = 0; i < 4; i++) push_step(4'd0, 4'b1000, 8'd0, 1'b0, e(OW_GD, 1'b1, 4'd0, 4'd0));
        push_step(4'd0, 4'b1000, 8'd0, 1'b0, e(OW_IDLE, 1'b1, 4'd0, 4'd0));
        push_step(4'd0, 4'b1000, 8'd0, 1'b0, e(OW_KB, 1'b1, 4'd0, 4'b1000));
        push_step(4'd0, 4'b1000, 8'd0, 1'b1, e(OW_KB, 1'b0, 4'd0, 4'b1000));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_KB, 1'b0, 4'd0, 4'b1000));
        for (int i = 0; i < 4; i++) push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_GD, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = observed_out();
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("[TB] FAIL keyboard_preempt step %0d: got %b expected %b", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_stop_and_ignore();
        stim_t s;
        logic [11:0] want, got;
        int step = 0;
        push_step(4'd0, 4'd0, 8'd1, 1'b1, e(OW_IDLE, 1'b1, 4'd0, 4'd0));
        for (int i = 0; i < 4; i++) push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_BT, 1'b1, 4'b0001, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b1, e(OW_BT, 1'b0, 4'b0001, 4'd0));
        for (int i = 0; i < 4; i++) push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_GD, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd9, 1'b1, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'h41, 1'b1, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
`ifndef ARB_ESTOP_EN
        push_step(4'd0, 4'd0, 8'hFF, 1'b1, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'hFE, 1'b1, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
`endif
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = observed_out();
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("[TB] FAIL stop_and_ignore step %0d: got %b expected %b", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_retarget();
        stim_t s;
        logic [11:0] want, got;
        int step = 0;
        push_step(4'd0, 4'd0, 8'd1, 1'b1, e(OW_IDLE, 1'b1, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_BT, 1'b1, 4'b0001, 4'd0));
        push_step(4'd0, 4'd0, 8'd8, 1'b1, e(OW_BT, 1'b1, 4'b0001, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_BT, 1'b1, 4'd0, 4'b1000));
        push_step(4'd0, 4'd0, 8'd9, 1'b1, e(OW_BT, 1'b1, 4'd0, 4'b1000));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_BT, 1'b1, 4'd0, 4'b1000));
        push_step(4'd0, 4'd0, 8'd0, 1'b1, e(OW_BT, 1'b0, 4'd0, 4'b1000));
        for (int i = 0; i < 4; i++) push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_GD, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = observed_out();
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("[TB] FAIL retarget step %0d: got %b expected %b", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_expiry_reload();
        stim_t s;
        logic [11:0] want, got;
        int step = 0;
        push_step(4'd0, 4'd0, 8'd2, 1'b1, e(OW_IDLE, 1'b1, 4'd0, 4'd0));
        for (int i = 0; i < 19; i++) push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_BT, 1'b1, 4'd0, 4'b0001));
        push_step(4'd0, 4'd0, 8'd7, 1'b1, e(OW_BT, 1'b1, 4'd0, 4'b0001));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_BT, 1'b1, 4'b1000, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b1, e(OW_BT, 1'b0, 4'b1000, 4'd0));
        for (int i = 0; i < 4; i++) push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_GD, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = observed_out();
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("[TB] FAIL expiry_reload step %0d: got %b expected %b", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_conflict();
        stim_t s;
        logic [11:0] want, got;
        int step = 0;
        push_step(4'b0011, 4'b0011, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'b0011, 4'b0011, 8'd0, 1'b0, e(OW_KB, 1'b0, 4'd0, 4'd0));
        push_step(4'b1100, 4'b0100, 8'd0, 1'b0, e(OW_KB, 1'b0, 4'd0, 4'd0));
        push_step(4'b0001, 4'b0010, 8'd0, 1'b0, e(OW_KB, 1'b0, 4'b1000, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_KB, 1'b0, 4'b0001, 4'b0010));
        for (int i = 0; i < 4; i++) push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_GD, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = observed_out();
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("[TB] FAIL conflict step %0d: got %b expected %b", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_guard_hold();
        stim_t s;
        logic [11:0] want, got;
        int step = 0;
        push_step(4'b0100, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_KB, 1'b0, 4'b0100, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_GD, 1'b0, 4'd0, 4'd0));
        push_step(4'b0010, 4'd0, 8'd3, 1'b1, e(OW_GD, 1'b1, 4'd0, 4'd0));
        push_step(4'b0010, 4'd0, 8'd0, 1'b0, e(OW_GD, 1'b1, 4'd0, 4'd0));
        push_step(4'b0010, 4'd0, 8'd0, 1'b0, e(OW_GD, 1'b1, 4'd0, 4'd0));
        push_step(4'b0010, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b1, 4'd0, 4'd0));
        push_step(4'b0010, 4'd0, 8'd0, 1'b1, e(OW_KB, 1'b0, 4'b0010, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_KB, 1'b0, 4'b0010, 4'd0));
        for (int i = 0; i < 4; i++) push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_GD, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = observed_out();
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("[TB] FAIL guard_hold step %0d: got %b expected %b", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_reset_mid_op();
        stim_t s;
        logic [11:0] want, got;
        int step = 0;
        push_step(4'd0, 4'd0, 8'd5, 1'b1, e(OW_IDLE, 1'b1, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_BT, 1'b1, 4'b0100, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_BT, 1'b1, 4'b0100, 4'd0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = observed_out();
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("[TB] FAIL reset_mid_op step %0d: got %b expected %b", step, got, want);
            end
            step++;
        end
        rst_n = 1'b0;
        #1;
        got = observed_out();
        n_compared++;
        if (got !== 12'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_op async: got %b expected %b", got, 12'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) push_step(4'd0, 4'd0, 8'd0, 1'b0, e(OW_IDLE, 1'b0, 4'd0, 4'd0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = observed_out();
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("[TB] FAIL reset_mid_op after step %0d: got %b expected %b", step, got, want);
            end
            step++;
        end
    endtask

`ifdef ARB_ESTOP_EN
    task automatic test_estop();
        stim_t s;
        logic [11:0] want, got;
        int step = 0;
        push_step(4'd0, 4'd0, 8'd3, 1'b1, ex(1'b0, OW_IDLE, 1'b1, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, ex(1'b0, OW_BT, 1'b1, 4'b0010, 4'd0));
        push_step(4'd0, 4'd0, 8'hFF, 1'b1, ex(1'b1, OW_BT, 1'b0, 4'b0010, 4'd0));
        for (int i = 0; i < 4; i++) push_step(4'd0, 4'd0, 8'd0, 1'b0, ex(1'b1, OW_GD, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, ex(1'b1, OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd4, 1'b1, ex(1'b1, OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'b0001, 4'd0, 8'd0, 1'b0, ex(1'b1, OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'b0001, 4'd0, 8'd0, 1'b0, ex(1'b1, OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'hFE, 1'b1, ex(1'b0, OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, ex(1'b0, OW_IDLE, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd4, 1'b1, ex(1'b0, OW_IDLE, 1'b1, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, ex(1'b0, OW_BT, 1'b1, 4'd0, 4'b0010));
        push_step(4'd0, 4'd0, 8'd0, 1'b1, ex(1'b0, OW_BT, 1'b0, 4'd0, 4'b0010));
        for (int i = 0; i < 4; i++) push_step(4'd0, 4'd0, 8'd0, 1'b0, ex(1'b0, OW_GD, 1'b0, 4'd0, 4'd0));
        push_step(4'd0, 4'd0, 8'd0, 1'b0, ex(1'b0, OW_IDLE, 1'b0, 4'd0, 4'd0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            applyStimulus(s);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = observed_out();
            n_compared++;
            if (got !== want) begin
                n_mismatched++;
                $display("[TB] FAIL estop step %0d: got %b expected %b", step, got, want);
            end
            step++;
        end
    endtask
`endif

    // Safety net so a stuck run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_keyboard_basic();
        test_bluetooth_expiry();
        test_keyboard_preempt();
        test_stop_and_ignore();
        test_retarget();
        test_expiry_reload();
        test_conflict();
        test_guard_hold();
        test_reset_mid_op();
`ifdef ARB_ESTOP_EN
        test_estop();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
